// File: rtl/cpu_regfile_if.sv
// Writeback write port and the two decode read ports of cpu_regfile.
// The commit-trace signals exist only when CPU_REGFILE_TRACE_EN is defined.
interface cpu_regfile_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              we_i;
   logic [ADDR_W-1:0] waddr_i;
   logic [DATA_W-1:0] wdata_i;
   logic [ADDR_W-1:0] raddr1_i;
   logic [ADDR_W-1:0] raddr2_i;
   logic [DATA_W-1:0] rdata1_o;
   logic [DATA_W-1:0] rdata2_o;
`ifdef CPU_REGFILE_TRACE_EN
   logic              trace_valid_o;
   logic [ADDR_W-1:0] trace_addr_o;
   logic [DATA_W-1:0] trace_data_o;
   logic [31:0]       commit_count_o;
`endif

   modport master (
      output we_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
      input  rdata1_o, rdata2_o
`ifdef CPU_REGFILE_TRACE_EN
      , input trace_valid_o, trace_addr_o, trace_data_o, commit_count_o
`endif
   );

   modport slave (
      input  we_i, waddr_i, wdata_i, raddr1_i, raddr2_i,
      output rdata1_o, rdata2_o
`ifdef CPU_REGFILE_TRACE_EN
      , output trace_valid_o, trace_addr_o, trace_data_o, commit_count_o
`endif
   );
endinterface

// File: rtl/cpu_regfile.sv
// 32x32 register file: $zero hardwired, two combinational read ports with optional
// same-cycle write bypass. Define CPU_REGFILE_TRACE_EN to add the commit trace outputs.
module cpu_regfile #(
   parameter int REG_NUM      = 32,
   parameter int DATA_WIDTH   = 32,
   parameter bit WRITE_BYPASS = 1'b1
) (
   input logic          clk,
   input logic          rst,
   cpu_regfile_if.slave bus
);
   localparam int ADDR_W = $clog2(REG_NUM);
   localparam logic [ADDR_W-1:0]     ZERO_ADDR = {ADDR_W{1'b0}};
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] regs [REG_NUM];
   logic                  write_ok;

   assign write_ok = !rst && bus.we_i && (bus.waddr_i != ZERO_ADDR);

   function automatic logic [DATA_WIDTH-1:0] read_sel(
      input logic                  rst_v,
      input logic                  we_v,
      input logic [ADDR_W-1:0]     waddr_v,
      input logic [DATA_WIDTH-1:0] wdata_v,
      input logic [ADDR_W-1:0]     raddr_v,
      input logic [DATA_WIDTH-1:0] stored_v
   );
      logic [DATA_WIDTH-1:0] res;
      res = ZERO_DATA;
      if (rst_v) begin
         res = ZERO_DATA;
      end else if (raddr_v == ZERO_ADDR) begin
         res = ZERO_DATA;
      end else if (WRITE_BYPASS && we_v && (waddr_v == raddr_v)) begin
         res = wdata_v;
      end else begin
         res = stored_v;
      end
      return res;
   endfunction

   // Entry 0 is cleared by reset and never written, so it always holds zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs[i] <= ZERO_DATA;
         end
      end else if (write_ok) begin
         regs[bus.waddr_i] <= bus.wdata_i;
      end
   end

   // Read port 1 select.
   always_comb begin
      bus.rdata1_o = read_sel(rst, bus.we_i, bus.waddr_i, bus.wdata_i,
                              bus.raddr1_i, regs[bus.raddr1_i]);
   end

   // Read port 2 select.
   always_comb begin
      bus.rdata2_o = read_sel(rst, bus.we_i, bus.waddr_i, bus.wdata_i,
                              bus.raddr2_i, regs[bus.raddr2_i]);
   end

`ifdef CPU_REGFILE_TRACE_EN
   // Commit trace: one registered record per accepted write; addr/data hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.trace_valid_o  <= 1'b0;
         bus.trace_addr_o   <= ZERO_ADDR;
         bus.trace_data_o   <= ZERO_DATA;
         bus.commit_count_o <= 32'd0;
      end else if (write_ok) begin
         bus.trace_valid_o  <= 1'b1;
         bus.trace_addr_o   <= bus.waddr_i;
         bus.trace_data_o   <= bus.wdata_i;
         bus.commit_count_o <= bus.commit_count_o + 32'd1;
      end else begin
         bus.trace_valid_o  <= 1'b0;
      end
   end
`endif
endmodule
